bp_network_flit_arbiter: RTL and testbench

Round-robin arbiter that shares one `bp_network_serializer` instance between `num_req_p` requesters on the same network port. It grants one requester at a time, forwards that requester's parallel message into the serializer, and holds the grant until the serializer's output handshake shows that the last flit of the message has left. Flits from different messages therefore never interleave on the link. The block sits between the coherence/memory-engine message sources and the serializer feeding the router.

---
 rtl/bp_network_flit_arbiter_pkg.sv | 16 +
 rtl/bp_network_flit_arbiter_if.sv | 33 +++
 rtl/bp_network_flit_arbiter_rr_pick.sv | 31 +++
 rtl/bp_network_flit_arbiter.sv | 116 +++++++++++
 tb/tb_bp_network_flit_arbiter.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/bp_network_flit_arbiter_pkg.sv
// Shared definitions for the flit arbiter: FSM encoding and the flit-count
// calculation that must agree with the serializer it feeds.
package bp_network_flit_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_OFFER = 2'd1,
      ST_DRAIN = 2'd2
   } arb_state_e;

   // Number of flits the serializer emits for one message (header flit included)
   function automatic int num_flits(input int source_w, input int packet_w);
      return source_w / packet_w + 1;
   endfunction

endpackage

// File: rtl/bp_network_flit_arbiter_if.sv
// Bundle of requester-side and serializer-side signals around the flit arbiter.
// The arbiter uses the slave view; the environment (requesters, serializer,
// link monitor) drives it through the master view.
interface bp_network_flit_arbiter_if
   import bp_network_flit_arbiter_pkg::*;
#(
   parameter int num_req_p           = 4,
   parameter int source_data_width_p = 64
);
   localparam int id_width_lp = $clog2(num_req_p);

   logic [num_req_p-1:0]                     req_v_i;
   logic [num_req_p*source_data_width_p-1:0] req_data_i;
   logic [num_req_p-1:0]                     req_ready_o;
   logic                                     ser_v_o;
   logic [source_data_width_p-1:0]           ser_data_o;
   logic                                     ser_ready_i;
   logic                                     flit_v_i;
   logic                                     flit_yumi_i;
   logic [id_width_lp-1:0]                   grant_id_o;
   logic                                     busy_o;

   modport master (
      output req_v_i, req_data_i, ser_ready_i, flit_v_i, flit_yumi_i,
      input  req_ready_o, ser_v_o, ser_data_o, grant_id_o, busy_o
   );

   modport slave (
      input  req_v_i, req_data_i, ser_ready_i, flit_v_i, flit_yumi_i,
      output req_ready_o, ser_v_o, ser_data_o, grant_id_o, busy_o
   );

endinterface

// File: rtl/bp_network_flit_arbiter_rr_pick.sv
// Rotating-priority encoder: returns the first valid requester found when
// searching upward from the one after the last grant, wrapping around.
module bp_network_flit_arbiter_rr_pick
   import bp_network_flit_arbiter_pkg::*;
#(
   parameter  int num_req_p   = 4,
   localparam int id_width_lp = $clog2(num_req_p)
)(
   input  logic [num_req_p-1:0]   i_req_v,
   input  logic [id_width_lp-1:0] i_last_grant,
   output logic [id_width_lp-1:0] o_id,
   output logic                   o_any_v
);

   int w_idx;

   // Walk the requesters in priority order, keeping the first valid one
   always_comb begin
      o_id    = '0;
      o_any_v = 1'b0;
      w_idx   = 0;
      for (int i = 1; i <= num_req_p; i++) begin
         w_idx = (int'(i_last_grant) + i) % num_req_p;
         if (!o_any_v && i_req_v[id_width_lp'(w_idx)]) begin
            o_any_v = 1'b1;
            o_id    = id_width_lp'(w_idx);
         end
      end
   end

endmodule

// File: rtl/bp_network_flit_arbiter.sv
// Round-robin arbiter sharing one serializer between several message sources.
// A grant is held from selection until the last flit of the granted message
// has been taken by the link, so messages never interleave on the wire.
module bp_network_flit_arbiter
   import bp_network_flit_arbiter_pkg::*;
#(
   parameter int num_req_p           = 4,
   parameter int dest_id_width_p     = 4,
   parameter int source_data_width_p = 64,
   parameter int packet_data_width_p = 16
)(
   input  logic                        clk_i,
   input  logic                        reset_n_i,
   bp_network_flit_arbiter_if.slave    bus
);

   localparam int num_flits_lp = num_flits(source_data_width_p, packet_data_width_p);
   localparam int cnt_width_lp = $clog2(num_flits_lp + 1);
   localparam int id_width_lp  = $clog2(num_req_p);
   localparam logic [cnt_width_lp-1:0] last_flit_lp = cnt_width_lp'(num_flits_lp - 1);

   // Reject configurations the arbiter cannot serve; the destination ID has
   // to fit inside the message it is carried in.
   if (num_req_p < 2 || packet_data_width_p < 1 || dest_id_width_p < 1 ||
       dest_id_width_p > source_data_width_p) begin : g_bad_params
      $error("bp_network_flit_arbiter: illegal parameter combination");
   end

   arb_state_e                r_state;
   logic [id_width_lp-1:0]    r_grant;
   logic [id_width_lp-1:0]    r_last_grant;
   logic [cnt_width_lp-1:0]   r_flit_cnt;

   logic [id_width_lp-1:0]    w_pick_id;
   logic                      w_pick_any;
   logic                      w_ser_v;
   logic [num_req_p-1:0]      w_req_ready;
   logic                      w_flit_hs;
   logic [source_data_width_p-1:0] w_req_msg [num_req_p];

   // Unpack the flat request bus into one message per requester
   for (genvar k = 0; k < num_req_p; k++) begin : g_unpack
      assign w_req_msg[k] = bus.req_data_i[k*source_data_width_p +: source_data_width_p];
   end

   bp_network_flit_arbiter_rr_pick #(
      .num_req_p (num_req_p)
   ) u_pick (
      .i_req_v      (bus.req_v_i),
      .i_last_grant (r_last_grant),
      .o_id         (w_pick_id),
      .o_any_v      (w_pick_any)
   );

   assign w_flit_hs = bus.flit_v_i & bus.flit_yumi_i;

   // Only the granted requester is forwarded, and only while offering
   always_comb begin
      w_ser_v     = 1'b0;
      w_req_ready = '0;
      if (r_state == ST_OFFER) begin
         w_ser_v              = bus.req_v_i[r_grant];
         w_req_ready[r_grant] = bus.ser_ready_i;
      end
   end

   // Grant FSM: select in IDLE, hand the message over in OFFER, count flits out in DRAIN
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_state      <= ST_IDLE;
         r_grant      <= '0;
         r_last_grant <= id_width_lp'(num_req_p - 1);
         r_flit_cnt   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_pick_any) begin
                  r_grant <= w_pick_id;
                  r_state <= ST_OFFER;
               end
            end
            ST_OFFER: begin
               // A requester dropping valid here simply stalls the offer
               if (w_ser_v && bus.ser_ready_i) begin
                  r_flit_cnt <= '0;
                  r_state    <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (w_flit_hs) begin
                  if (r_flit_cnt == last_flit_lp) begin
                     r_flit_cnt   <= '0;
                     r_last_grant <= r_grant;
                     r_state      <= ST_IDLE;
                  end else begin
                     r_flit_cnt <= r_flit_cnt + 1'b1;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.ser_v_o     = w_ser_v;
   assign bus.ser_data_o  = (r_state == ST_OFFER) ? w_req_msg[r_grant] : '0;
   assign bus.req_ready_o = w_req_ready;
   assign bus.grant_id_o  = r_grant;
   assign bus.busy_o      = (r_state != ST_IDLE);

   // The serializer can only be emitting flits for a message we handed it
   a_flit_only_in_drain : assert property (
      @(posedge clk_i) disable iff (!reset_n_i) bus.flit_v_i |-> (r_state == ST_DRAIN)
   );

endmodule

// File: tb/tb_bp_network_flit_arbiter.sv
// Directed-vector bench for bp_network_flit_arbiter (4 requesters, 64-bit
// messages, 16-bit flits -> 5 flits per message).
module tb_bp_network_flit_arbiter;

   logic clk;
   logic rst_n;

   bp_network_flit_arbiter_if #(.num_req_p(4), .source_data_width_p(64)) arb_if ();

   bp_network_flit_arbiter #(
      .num_req_p           (4),
      .dest_id_width_p     (4),
      .source_data_width_p (64),
      .packet_data_width_p (16)
   ) dut (
      .clk_i     (clk),
      .reset_n_i (rst_n),
      .bus       (arb_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  rv;
      logic        rdy;
      logic        fv;
      logic        fy;
      logic        sv;
      logic [3:0]  rr;
      logic [1:0]  gid;
      logic        busy;
      logic [63:0] data;
      string       nm;
   } vec_t;

   vec_t        tbl[$];
   logic [63:0] msg [4];
   int          n_vec;
   int          n_bad;

   function automatic vec_t mk(input logic [3:0] rv, input logic rdy, input logic fv,
                               input logic fy, input logic sv, input logic [3:0] rr,
                               input logic [1:0] gid, input logic busy,
                               input logic [63:0] data, input string nm);
      vec_t v;
      v.rv = rv; v.rdy = rdy; v.fv = fv; v.fy = fy;
      v.sv = sv; v.rr = rr; v.gid = gid; v.busy = busy; v.data = data; v.nm = nm;
      return v;
   endfunction

   task automatic check(input string nm, input logic sv, input logic [3:0] rr,
                        input logic [1:0] gid, input logic busy, input logic [63:0] data);
      n_vec++;
      if (arb_if.ser_v_o !== sv || arb_if.req_ready_o !== rr || arb_if.grant_id_o !== gid ||
          arb_if.busy_o !== busy || arb_if.ser_data_o !== data) begin
         n_bad++;
         $display("FAIL %s @%0t: got sv=%b ready=%b grant=%0d busy=%b data=%h ; want sv=%b ready=%b grant=%0d busy=%b data=%h",
                  nm, $time, arb_if.ser_v_o, arb_if.req_ready_o, arb_if.grant_id_o,
                  arb_if.busy_o, arb_if.ser_data_o, sv, rr, gid, busy, data);
      end
   endtask

   // Called just after a rising edge; drives one cycle and checks mid-cycle
   task automatic apply(input vec_t v);
      arb_if.req_v_i     = v.rv;
      arb_if.ser_ready_i = v.rdy;
      arb_if.flit_v_i    = v.fv;
      arb_if.flit_yumi_i = v.fy;
      @(negedge clk);
      check(v.nm, v.sv, v.rr, v.gid, v.busy, v.data);
      @(posedge clk);
      #1;
   endtask

   task automatic run_table();
      foreach (tbl[i]) apply(tbl[i]);
      tbl.delete();
   endtask

   task automatic do_reset();
      arb_if.req_v_i     = '0;
      arb_if.ser_ready_i = 1'b0;
      arb_if.flit_v_i    = 1'b0;
      arb_if.flit_yumi_i = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] yumi_pat;
      int         prev;
      int         g;
      n_vec = 0;
      n_bad = 0;
      msg[0] = 64'h1000_0000_0000_00A0;
      msg[1] = 64'h2111_2222_3333_4444;
      msg[2] = 64'hDEAD_BEEF_0123_4567;
      msg[3] = 64'h3333_4444_5555_6666;
      arb_if.req_data_i  = {msg[3], msg[2], msg[1], msg[0]};
      arb_if.req_v_i     = '0;
      arb_if.ser_ready_i = 1'b0;
      arb_if.flit_v_i    = 1'b0;
      arb_if.flit_yumi_i = 1'b0;
      rst_n = 1'b0;
      #2;
      check("reset_values", 1'b0, 4'b0000, 2'd0, 1'b0, 64'h0);
      do_reset();

      // Idle after reset, then a single message from requester 2
      for (int i = 0; i < 20; i++)
         tbl.push_back(mk(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 64'h0, "idle_after_reset"));
      tbl.push_back(mk(4'b0100, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 64'h0, "req2_select"));
      tbl.push_back(mk(4'b0100, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0100, 2'd2, 1'b1, msg[2], "req2_offer"));
      for (int i = 0; i < 5; i++)
         tbl.push_back(mk(4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 2'd2, 1'b1, 64'h0, "req2_drain"));
      tbl.push_back(mk(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd2, 1'b0, 64'h0, "req2_back_idle"));
      run_table();

      // All four requesters continuously valid: grants 0,1,2,3,0
      do_reset();
      prev = 0;
      for (int m = 0; m < 5; m++) begin
         g = m % 4;
         tbl.push_back(mk(4'b1111, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 2'(prev), 1'b0, 64'h0, "rr_idle"));
         tbl.push_back(mk(4'b1111, 1'b1, 1'b0, 1'b0, 1'b1, 4'(1 << g), 2'(g), 1'b1, msg[g], "rr_offer"));
         for (int f = 0; f < 5; f++)
            tbl.push_back(mk(4'b1111, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 2'(g), 1'b1, 64'h0, "rr_drain"));
         prev = g;
      end
      run_table();

      // Requester 1 stalled in OFFER while requester 0 becomes valid
      do_reset();
      apply(mk(4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 64'h0, "stall_select"));
      for (int i = 0; i < 6; i++)
         apply(mk(4'b0011, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 2'd1, 1'b1, msg[1], "stall_hold"));
      apply(mk(4'b0011, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0010, 2'd1, 1'b1, msg[1], "stall_accept"));
      for (int i = 0; i < 5; i++)
         apply(mk(4'b0001, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 2'd1, 1'b1, 64'h0, "stall_drain"));
      apply(mk(4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd1, 1'b0, 64'h0, "next_select"));
      apply(mk(4'b0001, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0001, 2'd0, 1'b1, msg[0], "next_offer_req0"));

      // Link yumi toggling 1,0,0,1,1,0,1,1: fifth handshake is the last cycle
      yumi_pat = 8'b1101_1001;
      for (int i = 0; i < 8; i++)
         apply(mk(4'b0000, 1'b1, 1'b1, yumi_pat[i], 1'b0, 4'b0000, 2'd0, 1'b1, 64'h0, "yumi_toggle_drain"));
      apply(mk(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 64'h0, "yumi_busy_falls"));

      // Reset pulsed after two flits of a requester-3 message
      apply(mk(4'b1000, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 64'h0, "rst_select3"));
      apply(mk(4'b1000, 1'b1, 1'b0, 1'b0, 1'b1, 4'b1000, 2'd3, 1'b1, msg[3], "rst_offer3"));
      for (int i = 0; i < 2; i++)
         apply(mk(4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 2'd3, 1'b1, 64'h0, "rst_drain3"));
      arb_if.req_v_i     = 4'b1001;
      arb_if.flit_v_i    = 1'b1;
      arb_if.flit_yumi_i = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset_outputs", 1'b0, 4'b0000, 2'd0, 1'b0, 64'h0);
      arb_if.flit_v_i = 1'b0;
      @(negedge clk);
      check("reset_held", 1'b0, 4'b0000, 2'd0, 1'b0, 64'h0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      apply(mk(4'b1001, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0001, 2'd0, 1'b1, msg[0], "priority_req0_after_reset"));
      for (int i = 0; i < 5; i++)
         apply(mk(4'b1000, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b1, 64'h0, "post_reset_drain"));
      apply(mk(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 64'h0, "post_reset_idle"));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
